// File: rtl/wb_pkg.sv
// Shared writeback definitions: mux source encodings and the sequencer state type.
// The writeback mux and the sequencer decode both use these constants.
package wb_pkg;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_JAL = 2'b01;
  localparam logic [1:0] WB_ILL = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    ERR
  } wb_state_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Load-wait timeout counter: counts enabled cycles and flags the last allowed one.
// expired is high only while enabled, so an ack in that same cycle can still win.
module wb_timeout_ctr #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == (limit - 1'b1));

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: drives the writeback mux select and register-file write port,
// and stalls fetch while a load waits on the variable-latency data-memory handshake.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [1:0] wb_src,
  input  logic [4:0] rd,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic [1:0] wb_sel,
  output logic       rf_we,
  output logic [4:0] rf_waddr,
  output logic       stall,
  output logic       err_illegal,
  output logic       err_bus
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  wb_state_t  state, state_next;
  logic [4:0] rd_q;
  logic       ctr_clear, ctr_en, expired;
  logic       load_issue, ill_issue;

  wb_timeout_ctr #(.CW(CW)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .limit  (LIMIT),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_q        <= '0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_next;
      err_illegal <= ill_issue;
      if (load_issue) rd_q <= rd;
    end
  end

  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    wb_sel     = WB_ALU;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    stall      = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    load_issue = 1'b0;
    ill_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          wb_sel   = wb_src;
          rf_waddr = rd;
          case (wb_src)
            WB_MEM: begin
              stall      = 1'b1;
              load_issue = 1'b1;
              ctr_clear  = 1'b1;
              state_next = LOAD_WAIT;
            end
            WB_JAL, WB_ALU: rf_we = (rd != 5'd0);
            WB_ILL: ill_issue = 1'b1;
            default: ;
          endcase
        end
      end
      LOAD_WAIT: begin
        dmem_req = 1'b1;
        wb_sel   = WB_MEM;
        rf_waddr = rd_q;
        if (dmem_ack) begin
          rf_we      = (rd_q != 5'd0);
          state_next = IDLE;
        end else begin
          stall  = 1'b1;
          ctr_en = 1'b1;
          if (expired) state_next = ERR;
        end
      end
      ERR: stall = 1'b1;
      default: state_next = IDLE;
    endcase
    // A reset cycle must never commit a register write, even if an ack arrives with it.
    if (rst) rf_we = 1'b0;
  end

  assign err_bus = (state == ERR);

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench for wb_sequencer: a transaction-level model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_wb_sequencer;

  localparam int TIMEOUT = 4;

  typedef struct packed {
    logic       req;
    logic [1:0] sel;
    logic       we;
    logic [4:0] waddr;
    logic       stall;
    logic       ill;
    logic       bus;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [1:0] wb_src;
  logic [4:0] rd;
  logic       dmem_ack;
  logic       dmem_req;
  logic [1:0] wb_sel;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic       stall;
  logic       err_illegal;
  logic       err_bus;

  int checks = 0;
  int fails  = 0;
  exp_t exp_q[$];

  // Reference model state: is a load outstanding, how long has it waited, has it timed out.
  bit         m_loading;
  bit         m_err;
  bit         m_ill;
  int         m_waits;
  logic [4:0] m_rd;

  wb_sequencer #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .wb_src     (wb_src),
    .rd         (rd),
    .dmem_ack   (dmem_ack),
    .dmem_req   (dmem_req),
    .wb_sel     (wb_sel),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .stall      (stall),
    .err_illegal(err_illegal),
    .err_bus    (err_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_loading = 0;
    m_err     = 0;
    m_ill     = 0;
    m_waits   = 0;
    m_rd      = '0;
  endtask

  task automatic applyStimulus(input bit r, input bit iv, input logic [1:0] src,
                               input logic [4:0] d, input bit ack);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; instr_valid = iv; wb_src = src; rd = d; dmem_ack = ack;
    e = '{req: 1'b0, sel: 2'b11, we: 1'b0, waddr: 5'd0, stall: 1'b0, ill: m_ill, bus: 1'b0};
    if (m_err) begin
      e.stall = 1'b1;
      e.bus   = 1'b1;
    end else if (m_loading) begin
      e.req   = 1'b1;
      e.sel   = 2'b00;
      e.waddr = m_rd;
      e.we    = ack && (m_rd != 0) && !r;
      e.stall = !ack;
    end else if (iv) begin
      e.sel   = src;
      e.waddr = d;
      e.we    = (src[0] == 1'b1) && (d != 0) && !r;
      e.stall = (src == 2'b00);
    end
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      m_ill = !m_err && !m_loading && iv && (src == 2'b10);
      if (m_loading) begin
        if (ack) m_loading = 0;
        else begin
          m_waits++;
          if (m_waits == TIMEOUT) begin
            m_loading = 0;
            m_err     = 1;
          end
        end
      end else if (!m_err && iv && src == 2'b00) begin
        m_loading = 1;
        m_waits   = 0;
        m_rd      = d;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("dmem_req", int'(dmem_req), int'(e.req));
      checkOutput("wb_sel", int'(wb_sel), int'(e.sel));
      checkOutput("rf_we", int'(rf_we), int'(e.we));
      checkOutput("rf_waddr", int'(rf_waddr), int'(e.waddr));
      checkOutput("stall", int'(stall), int'(e.stall));
      checkOutput("err_illegal", int'(err_illegal), int'(e.ill));
      checkOutput("err_bus", int'(err_bus), int'(e.bus));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'b00, 5'd0, 0);
  endtask

  task automatic load(input logic [4:0] d, input int ack_after);
    applyStimulus(0, 1, 2'b00, d, 0);
    for (int i = 1; i < ack_after; i++) applyStimulus(0, 1, 2'b11, 5'd7, 0);
    applyStimulus(0, 1, 2'b11, 5'd7, 1);
  endtask

  initial begin
    rst = 1; instr_valid = 0; wb_src = 2'b00; rd = '0; dmem_ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    applyStimulus(1, 0, 2'b00, 5'd0, 0);
    idle(2);

    applyStimulus(0, 1, 2'b11, 5'd5, 0);
    applyStimulus(0, 1, 2'b01, 5'd0, 0);
    applyStimulus(0, 1, 2'b01, 5'd17, 1);
    load(5'd0, 1);
    load(5'd9, 3);
    load(5'd12, TIMEOUT);
    idle(1);

    applyStimulus(0, 1, 2'b00, 5'd3, 0);
    for (int i = 0; i < TIMEOUT + 2; i++) applyStimulus(0, 1, 2'b11, 5'd4, 0);
    applyStimulus(0, 0, 2'b00, 5'd0, 1);
    applyStimulus(0, 1, 2'b11, 5'd6, 1);
    applyStimulus(1, 0, 2'b00, 5'd0, 0);
    idle(1);

    applyStimulus(0, 1, 2'b10, 5'd8, 0);
    applyStimulus(0, 1, 2'b11, 5'd8, 0);
    idle(1);

    applyStimulus(0, 1, 2'b00, 5'd21, 0);
    applyStimulus(0, 0, 2'b00, 5'd0, 0);
    applyStimulus(1, 0, 2'b00, 5'd0, 0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 9) < 4);
    end
    idle(1);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
